// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit for the multi-cycle RV32 core.
//
// Holds the architectural PC, issues one read per instruction on a valid/ready
// memory read channel, hands {inst, pc} to decode, then waits for writeback to
// return the next PC. Exactly one instruction is in flight at any time.
//
// Optional feature: define IFU_RESP_CHECK_EN to turn a non-OKAY read response
// into an instruction access fault (ifu_fault) with a NOP substituted for the
// instruction word. Without the macro rresp is ignored and ifu_fault is 0.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  // Memory read channel
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        rready,
  // Decode handoff
  output logic        ifu_valid,
  output logic [63:0] ifu_data,
  input  logic        idu_ready,
  output logic        ifu_fault,
  // Writeback next-PC return
  input  logic        wbu_valid,
  input  logic [31:0] next_pc
);

  localparam logic [1:0] S_REQ     = 2'd0;
  localparam logic [1:0] S_RESP    = 2'd1;
  localparam logic [1:0] S_VALID   = 2'd2;
  localparam logic [1:0] S_WAIT_PC = 2'd3;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        fault_q, fault_d;

`ifndef IFU_RESP_CHECK_EN
  // Response code has no meaning when checking is disabled.
  logic unused_rresp;
  assign unused_rresp = ^rresp;
`endif

  // Next-state logic: each state waits on exactly one handshake input.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    unique case (state_q)
      S_REQ: begin
        if (arready) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rvalid) begin
          state_d = S_VALID;
`ifdef IFU_RESP_CHECK_EN
          fault_d = (rresp != 2'b00);
          // Decode sees a harmless word when the fetch faulted.
          inst_d  = (rresp != 2'b00) ? INST_NOP : rdata;
`else
          fault_d = 1'b0;
          inst_d  = rdata;
`endif
        end
      end
      S_VALID: begin
        if (idu_ready) begin
          state_d = S_WAIT_PC;
        end
      end
      S_WAIT_PC: begin
        if (wbu_valid) begin
          // Taken as-is; alignment is the producer's concern.
          pc_d    = next_pc;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // State registers; reset re-arms a fetch from RESET_PC and drops any pending data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

  // Handshake outputs decoded purely from state, so they are mutually exclusive.
  always_comb begin
    arvalid   = (state_q == S_REQ);
    rready    = (state_q == S_RESP);
    ifu_valid = (state_q == S_VALID);
    araddr    = pc_q;
    ifu_data  = {inst_q, pc_q};
    ifu_fault = fault_q & (state_q == S_VALID);
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the multi-cycle RV32 core. Holds the architectural PC, issues one instruction read per instruction over a valid/ready memory read channel, and presents `{inst, pc}` to the decode stage over the `ifu_valid`/`idu_ready` handshake. After handing off an instruction it waits for writeback to return the next PC before fetching again. This strictly serialises the core: one instruction in flight at a time.

## Interface
- `RESET_PC`, default `32'h8000_0000`: PC loaded on reset and used for the first fetch.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `araddr`  out  32  read address, always equal to the current PC.
- `arvalid`  out  1  read request valid.
- `arready`  in  1  memory accepts the request.
- `rvalid`  in  1  read data valid.
- `rdata`  in  32  instruction word.
- `rresp`  in  2  response code; `2'b00` means OKAY.
- `rready`  out  1  IFU accepts the read data.
- `ifu_valid`  out  1  `ifu_data` holds a fetched instruction.
- `ifu_data`  out  64  `{inst[31:0], pc[31:0]}`, with inst in the upper half.
- `idu_ready`  in  1  decode accepts `ifu_data`.
- `ifu_fault`  out  1  instruction fetch access fault; qualified by `ifu_valid`.
- `wbu_valid`  in  1  writeback has finished and `next_pc` is valid.
- `next_pc`  in  32  PC of the next instruction to fetch.

## Operation
- Four-state FSM: `S_REQ`, `S_RESP`, `S_VALID`, `S_WAIT_PC`.
- Registers: `pc`, `inst`, `fault`.
- `S_REQ`: drive `arvalid=1`, `araddr=pc`. Hold both until `arready=1`, then go to `S_RESP`.
- `S_RESP`: drive `rready=1`. When `rvalid=1`, latch `rdata` into `inst`, latch the fault bit (see Configuration), and go to `S_VALID`.
- `S_VALID`: drive `ifu_valid=1`. `ifu_data` stays stable until `idu_ready=1`, then go to `S_WAIT_PC`.
- `S_WAIT_PC`: all outputs inactive. When `wbu_valid=1`, load `pc <= next_pc` and go to `S_REQ`.
- `wbu_valid` is ignored in every state except `S_WAIT_PC`.
- `rvalid` is ignored outside `S_RESP`.
- `arvalid`, `rready` and `ifu_valid` are each decoded only from state, never combinationally from inputs. At most one of them is high in any cycle.
- `next_pc` is taken as-is, with no alignment check or masking.

## Timing
- While `rst_n=0`:
  - state = `S_REQ`, `pc=RESET_PC`, `inst=0`, `fault=0`.
  - Outputs: `arvalid=1`, `araddr=RESET_PC`, `rready=0`, `ifu_valid=0`, `ifu_data={32'h0, RESET_PC}`, `ifu_fault=0`.
  - The memory side must be held in reset concurrently, because the request is visible during reset.
- First rising edge after reset release, with `arready=1`: the request is accepted.
- Best-case latency, `arready` and `rvalid` both immediate:
  - request accepted at edge N;
  - `rvalid` sampled at edge N+1;
  - `ifu_valid` high in the cycle after N+1;
  - handoff at edge N+2 if `idu_ready=1`.
- `wbu_valid` in `S_WAIT_PC` at edge M puts `arvalid` high in the cycle after M, with `araddr=next_pc`.
- Minimum loop is 4 cycles per instruction: REQ, RESP, VALID, WAIT_PC.
- Back-pressure: any number of `arready=0`, `rvalid=0` or `idu_ready=0` cycles holds the current state. No output changes during these stalls.
- Reset asserted mid-operation in any state immediately forces the reset values above. The pending response and any un-consumed `ifu_data` are discarded.

## Configuration
- `IFU_RESP_CHECK_EN` defined:
  - In `S_RESP`, `fault <= (rresp != 2'b00)`.
  - `ifu_fault` reflects `fault` while `ifu_valid=1`, and is 0 otherwise.
  - `inst` is latched as `32'h0000_0013` (NOP) on a fault, so decode sees a harmless word.
- `IFU_RESP_CHECK_EN` undefined:
  - `rresp` is ignored.
  - `ifu_fault` is tied to 0.
  - `inst` always latches `rdata`.

## Test plan
- Reset, then `arready=1`, `rvalid=1`, `rdata=32'h0010_0093`, `idu_ready=1` → `araddr=32'h8000_0000`; `ifu_data=64'h0010_0093_8000_0000` presented for exactly one cycle; FSM then waits in `S_WAIT_PC`.
- After the handoff, `wbu_valid=1` with `next_pc=32'h8000_0004` → next cycle `arvalid=1`, `araddr=32'h8000_0004`. A `wbu_valid` pulse during `S_RESP` has no effect on `pc`.
- Stalls: `arready=0` for 3 cycles, then `rvalid` delayed 5 cycles, then `idu_ready=0` for 4 cycles → `arvalid`, `rready` and `ifu_valid` each held high for the whole stall, with `araddr` and `ifu_data` constant throughout.
- With `IFU_RESP_CHECK_EN`, `rresp=2'b10`, `rdata=32'hFFFF_FFFF` → `ifu_fault=1` and `ifu_data[63:32]=32'h0000_0013`. Without the macro, the same stimulus gives `ifu_fault=0` and `inst=32'hFFFF_FFFF`.
- Assert `rst_n=0` during `S_VALID` with `pc=32'h8000_0010` → `ifu_valid` drops immediately, `arvalid=1`, `araddr=32'h8000_0000`. After release, normal fetch resumes from `RESET_PC`.
